// File: rtl/param_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo_if
// Brief    : Handshake/data bundle for param_sync_fifo (slave = FIFO side).
// Revision : 1.0 - initial release
// ============================================================================
interface param_sync_fifo_if #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic              i_err_clr;
    logic [DATA_W-1:0] o_rddata;
    logic              o_rd_valid;
    logic              o_full;
    logic              o_alm_full;
    logic              o_empty;
    logic              o_alm_empty;
    logic [CNT_W-1:0]  o_count;
    logic              o_ovf;
    logic              o_udf;

    modport slave (
        input  i_wren, i_wrdata, i_rden, i_err_clr,
        output o_rddata, o_rd_valid, o_full, o_alm_full, o_empty, o_alm_empty,
               o_count, o_ovf, o_udf
    );

    modport master (
        output i_wren, i_wrdata, i_rden, i_err_clr,
        input  o_rddata, o_rd_valid, o_full, o_alm_full, o_empty, o_alm_empty,
               o_count, o_ovf, o_udf
    );
endinterface
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo
// Brief    : Single-clock FIFO, registered read data, occupancy flags.
//            Define PARAM_SYNC_FIFO_ERR_EN for sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    param_sync_fifo_if.slave   bus
);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int c_addr_w = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_af_lvl = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] c_ae_lvl = CNT_W'(AE_LVL);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_rddata;
    logic                r_rd_valid;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_ovf;
    logic                w_udf;

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    // When full a write is refused even if a read frees a slot on the same edge
    assign w_wr_acc = bus.i_wren && !w_full;
    assign w_rd_acc = bus.i_rden && !w_empty;

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !reset) begin
            r_mem[r_wr_ptr] <= bus.i_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rddata   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rddata <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    // A new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.i_wren && w_full) begin
                r_ovf <= 1'b1;
            end else if (bus.i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (bus.i_rden && w_empty) begin
                r_udf <= 1'b1;
            end else if (bus.i_err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign w_ovf = r_ovf;
    assign w_udf = r_udf;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = bus.i_err_clr;
    assign w_ovf            = 1'b0;
    assign w_udf            = 1'b0;
`endif

    assign bus.o_rddata    = r_rddata;
    assign bus.o_rd_valid  = r_rd_valid;
    assign bus.o_count     = r_count;
    assign bus.o_full      = w_full;
    assign bus.o_empty     = w_empty;
    assign bus.o_alm_full  = (r_count >= c_af_lvl);
    assign bus.o_alm_empty = (r_count <= c_ae_lvl);
    assign bus.o_ovf       = w_ovf;
    assign bus.o_udf       = w_udf;

endmodule
`default_nettype wire

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 128, data word width in bits (1..1024).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, 4..4096.
REQ-003 Parameter AF_LVL, default DEPTH-2, almost-full threshold in entries (1..DEPTH-1).
REQ-004 Parameter AE_LVL, default 2, almost-empty threshold in entries (1..DEPTH-1, < AF_LVL).
REQ-005 Derived width CNT_W = log2(DEPTH)+1.
REQ-006 clk  in  1  single clock for all logic, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 i_wren  in  1  write request.
REQ-009 i_wrdata  in  DATA_W  write data, sampled with i_wren.
REQ-010 i_rden  in  1  read request.
REQ-011 i_err_clr  in  1  clears sticky error flags.
REQ-012 o_rddata  out  DATA_W  read data, registered.
REQ-013 o_rd_valid  out  1  o_rddata carries a newly read word this cycle.
REQ-014 o_full / o_alm_full / o_empty / o_alm_empty  out  1 each  occupancy flags.
REQ-015 o_count  out  CNT_W  current occupancy, 0..DEPTH.
REQ-016 o_ovf / o_udf  out  1 each  sticky overflow / underflow flags.

Function
REQ-017 Write accepted (wr_acc) when i_wren=1 and o_full=0; data stored at write pointer, pointer increments.
REQ-018 Read accepted (rd_acc) when i_rden=1 and o_empty=0; entry at read pointer loaded into o_rddata on the same edge, pointer increments.
REQ-019 Read latency one cycle: o_rd_valid=1 in the cycle after rd_acc, else 0.
REQ-020 o_rddata holds its last value when no read is accepted.
REQ-021 Pointers wrap from DEPTH-1 to 0 with no gap or extra cycle.
REQ-022 o_count next = o_count + wr_acc - rd_acc; simultaneous accepted read and write leave count unchanged.
REQ-023 Full with i_wren=1 and i_rden=1: read accepted, write rejected (no pass-through); count becomes DEPTH-1.
REQ-024 Empty with i_wren=1 and i_rden=1: write accepted, read rejected; count becomes 1, o_rd_valid stays 0.
REQ-025 Flags decoded from registered o_count, no extra latency: o_full=(count==DEPTH), o_empty=(count==0), o_alm_full=(count>=AF_LVL), o_alm_empty=(count<=AE_LVL).
REQ-026 Rejected write/read changes no pointer, count or stored data.
REQ-027 No internal FSM beyond pointers/count; all outputs registered or decoded from registers.

Reset
REQ-028 reset=1 at a rising edge: pointers=0, o_count=0, o_rddata=0, o_rd_valid=0, o_ovf=0, o_udf=0; hence o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
REQ-029 reset overrides simultaneous i_wren/i_rden; reset mid-operation discards contents; storage array not cleared.
REQ-030 First write accepted on the first edge with reset=0.

Configuration
REQ-031 Macro PARAM_SYNC_FIFO_ERR_EN defined: o_ovf set on i_wren=1 while o_full=1, o_udf set on i_rden=1 while o_empty=1; both sticky until reset or i_err_clr=1; set in the same cycle as i_err_clr wins (flag stays 1).
REQ-032 Macro undefined: o_ovf and o_udf tied 0, i_err_clr ignored, port list unchanged.

Verification
REQ-033 Reset, then write 0x1..0x10 (DEPTH=16) back-to-back -> o_alm_full=1 after 14th write, o_full=1 after 16th, o_count=16.
REQ-034 Read 16 words after REQ-033 fill -> o_rddata=0x1..0x10 in order, o_rd_valid=1 each following cycle, o_alm_empty=1 at count 2, o_empty=1 at count 0.
REQ-035 Full, i_wren=1 and i_rden=1 with data 0xAA -> 0x1 read, 0xAA dropped, o_count=15; with ERR_EN o_ovf=1.
REQ-036 Empty, i_wren=1 and i_rden=1 with data 0x55 -> o_count=1, o_rd_valid=0; next read returns 0x55; with ERR_EN o_udf=1, cleared by i_err_clr pulse.
REQ-037 Stream 40 words with random i_wren/i_rden for wrap-around -> data order matches scoreboard, o_count never outside 0..16.
REQ-038 reset asserted at count=9 mid-stream -> next cycle o_count=0, o_empty=1, o_rd_valid=0, o_rddata=0.
